alu_operand_sequencer: RTL and testbench

//   Upstream stage of the 3-bit logic ALU on the board. Collects operand A, operand B
//   and the 2-bit op select from slide switches, one debounced "next" press per field.

---
 rtl/alu_operand_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Purpose: front end of the 3-bit logic ALU. It collects A, B and the op select from switches, one debounced press each, then captures the ALU result.
// Latency: a press is acted on DEBOUNCE_CYCLES+3 cycles after a clean raw rise. EXEC lasts 1 cycle, and the result is registered on the EXEC->SHOW edge.
// Backpressure: none. The FSM only advances on a next pulse, and a next pulse that arrives in EXEC is dropped.
//
// Ports:
//   i_clk, i_rst              system clock, synchronous active-high reset
//   i_sw_data, i_sw_sel       switch values loaded into A/B and into the op select
//   i_btn_next, i_btn_clear   raw, bouncy, asynchronous push buttons (active-high)
//   i_alu_result              combinational result from the ALU
//   o_op_a, o_op_b, o_op_s    registered operands and op select driven to the ALU
//   o_result_q, o_result_valid  captured result; valid is high for the whole of SHOW
//   o_phase                   one-hot LOAD_A/LOAD_B/LOAD_S indicator (000 in EXEC/SHOW)
//   o_op_count                completed operations, modulo 256
module alu_operand_sequencer #(
    parameter int WIDTH           = 3,
    parameter int SEL_W           = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sw_data,
    input  logic [SEL_W-1:0] i_sw_sel,
    input  logic             i_btn_next,
    input  logic             i_btn_clear,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic [WIDTH-1:0] o_op_a,
    output logic [WIDTH-1:0] o_op_b,
    output logic [SEL_W-1:0] o_op_s,
    output logic [WIDTH-1:0] o_result_q,
    output logic             o_result_valid,
    output logic [2:0]       o_phase,
    output logic [7:0]       o_op_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // One-hot state so the LOAD_* bits are the phase LEDs directly.
    typedef enum logic [4:0] {
        ST_LOAD_A = 5'b00001,
        ST_LOAD_B = 5'b00010,
        ST_LOAD_S = 5'b00100,
        ST_EXEC   = 5'b01000,
        ST_SHOW   = 5'b10000
    } state_t;

    // Bit 0 = next, bit 1 = clear; both buttons are conditioned identically.
    logic [1:0]            w_btn_raw;
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_db;
    logic [1:0]            r_arm;
    logic [1:0]            r_pulse;
    logic [1:0][CNT_W-1:0] r_cnt;

    state_t                r_state;
    logic [WIDTH-1:0]      r_op_a;
    logic [WIDTH-1:0]      r_op_b;
    logic [SEL_W-1:0]      r_op_s;
    logic [WIDTH-1:0]      r_result_q;
    logic                  r_result_valid;
    logic [7:0]            r_op_count;

    assign w_btn_raw = {i_btn_clear, i_btn_next};

    // The synchronizer just tracks the pin. It is deliberately not reset, so a
    // button held through reset is already seen as high when reset releases.
    always_ff @(posedge i_clk) begin
        r_sync1 <= w_btn_raw;
        r_sync2 <= r_sync1;
    end

    // Debounce: count consecutive cycles in which the synced level disagrees with
    // the accepted level, and flip the accepted level after DEBOUNCE_CYCLES of them.
    // r_arm only goes high once the button has been seen released after reset.
    // A button held through reset therefore never produces a pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_db    <= '0;
            r_arm   <= '0;
            r_pulse <= '0;
            r_cnt   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_pulse[i] <= 1'b0;
                if (!r_sync2[i]) begin
                    r_arm[i] <= 1'b1;
                end
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_cnt[i]   <= '0;
                    r_db[i]    <= r_sync2[i];
                    r_pulse[i] <= r_sync2[i] & r_arm[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Sequencer. A clear pulse overrides everything except reset and keeps the op count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_LOAD_A;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_op_s         <= '0;
            r_result_q     <= '0;
            r_result_valid <= 1'b0;
            r_op_count     <= '0;
        end else if (r_pulse[1]) begin
            r_state        <= ST_LOAD_A;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_op_s         <= '0;
            r_result_q     <= '0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD_A: if (r_pulse[0]) begin
                    r_op_a  <= i_sw_data;
                    r_state <= ST_LOAD_B;
                end
                ST_LOAD_B: if (r_pulse[0]) begin
                    r_op_b  <= i_sw_data;
                    r_state <= ST_LOAD_S;
                end
                ST_LOAD_S: if (r_pulse[0]) begin
                    r_op_s  <= i_sw_sel;
                    r_state <= ST_EXEC;
                end
                // The operands have been stable for a full cycle, so the ALU output has settled.
                ST_EXEC: begin
                    r_result_q     <= i_alu_result;
                    r_result_valid <= 1'b1;
                    r_op_count     <= r_op_count + 8'd1;
                    r_state        <= ST_SHOW;
                end
                ST_SHOW: if (r_pulse[0]) begin
                    r_result_valid <= 1'b0;
                    r_state        <= ST_LOAD_A;
                end
                default: r_state <= ST_LOAD_A;
            endcase
        end
    end

    assign o_op_a         = r_op_a;
    assign o_op_b         = r_op_b;
    assign o_op_s         = r_op_s;
    assign o_result_q     = r_result_q;
    assign o_result_valid = r_result_valid;
    assign o_phase        = r_state[2:0];
    assign o_op_count     = r_op_count;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;

    localparam int D    = 4;
    localparam int HOLD = 12;
    localparam int M_A = 0, M_B = 1, M_S = 2, M_X = 3, M_SH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sw_data = '0;
    logic [1:0] sw_sel = '0;
    logic       btn_next = 1'b0;
    logic       btn_clear = 1'b0;
    logic [2:0] alu_res;
    logic [2:0] op_a, op_b, result_q;
    logic [1:0] op_s;
    logic       result_valid;
    logic [2:0] phase;
    logic [7:0] op_count;

    int checks = 0;
    int failures = 0;
    bit en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [2:0] alu_f(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
        case (s)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign alu_res = alu_f(op_a, op_b, op_s);

    alu_operand_sequencer #(.WIDTH(3), .SEL_W(2), .DEBOUNCE_CYCLES(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_sw_data(sw_data), .i_sw_sel(sw_sel),
        .i_btn_next(btn_next), .i_btn_clear(btn_clear), .i_alu_result(alu_res),
        .o_op_a(op_a), .o_op_b(op_b), .o_op_s(op_s), .o_result_q(result_q),
        .o_result_valid(result_valid), .o_phase(phase), .o_op_count(op_count)
    );

    task automatic ck(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The button model is stated over the raw sample history. The accepted level
    // flips once the pin, seen two samples late, has disagreed with it for D edges in a row since reset.
    logic [31:0] h_n = '0, h_c = '0;
    logic m_db_n, m_db_c, m_arm_n, m_arm_c, m_p_n, m_p_c;
    int   since_rst;
    int   m_state;
    logic [2:0] m_a, m_b, m_res;
    logic [1:0] m_s;
    logic m_valid;
    int   m_count;

    function automatic logic [2:0] deb_step(input logic [31:0] h, input logic db, input logic arm, input int n);
        logic run, ndb, narm, p;
        ndb  = db;
        narm = arm;
        p    = 1'b0;
        run  = (n >= D);
        for (int j = 2; j <= D + 1; j++) if (h[j] == db) run = 1'b0;
        if (run) begin
            ndb = ~db;
            p   = ~db & arm;
        end
        if (!h[2]) narm = 1'b1;
        return {ndb, narm, p};
    endfunction

    always @(posedge clk) begin
        logic nxt, clr;
        logic [2:0] rn, rc;
        nxt = m_p_n;
        clr = m_p_c;
        h_n = {h_n[30:0], btn_next};
        h_c = {h_c[30:0], btn_clear};
        if (rst) begin
            m_db_n = 0; m_db_c = 0; m_arm_n = 0; m_arm_c = 0; m_p_n = 0; m_p_c = 0;
            since_rst = 0;
            m_state = M_A; m_a = 0; m_b = 0; m_s = 0; m_res = 0; m_valid = 0; m_count = 0;
        end else begin
            since_rst++;
            if (clr) begin
                m_state = M_A; m_a = 0; m_b = 0; m_s = 0; m_res = 0; m_valid = 0;
            end else begin
                case (m_state)
                    M_A: if (nxt) begin m_a = sw_data; m_state = M_B; end
                    M_B: if (nxt) begin m_b = sw_data; m_state = M_S; end
                    M_S: if (nxt) begin m_s = sw_sel; m_state = M_X; end
                    M_X: begin
                        m_res = alu_f(m_a, m_b, m_s);
                        m_count = (m_count + 1) % 256;
                        m_valid = 1;
                        m_state = M_SH;
                    end
                    default: if (nxt) begin m_valid = 0; m_state = M_A; end
                endcase
            end
            rn = deb_step(h_n, m_db_n, m_arm_n, since_rst);
            rc = deb_step(h_c, m_db_c, m_arm_c, since_rst);
            {m_db_n, m_arm_n, m_p_n} = rn;
            {m_db_c, m_arm_c, m_p_c} = rc;
        end
    end

    // Compare every cycle once the first reset has been applied.
    always @(negedge clk) begin
        if (en) begin
            ck("cyc_op_a", {5'd0, op_a}, {5'd0, m_a});
            ck("cyc_op_b", {5'd0, op_b}, {5'd0, m_b});
            ck("cyc_op_s", {6'd0, op_s}, {6'd0, m_s});
            ck("cyc_result_q", {5'd0, result_q}, {5'd0, m_res});
            ck("cyc_result_valid", {7'd0, result_valid}, {7'd0, m_valid});
            ck("cyc_phase", {5'd0, phase}, (m_state < 3) ? 8'(1 << m_state) : 8'd0);
            ck("cyc_op_count", op_count, 8'(m_count));
        end
    end

    // ---------------- stimulus ----------------
    int exec_seen;
    bit rst_on_exec = 0;
    bit rst_hit = 0;

    task automatic press(input bit nx, input bit cl);
        int rst_left;
        rst_left = 0;
        btn_next  = nx;
        btn_clear = cl;
        for (int i = 0; i < 2 * HOLD; i++) begin
            if (i == HOLD) begin
                btn_next  = 0;
                btn_clear = 0;
            end
            @(negedge clk);
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst = 0;
            end else if (phase == 3'b000 && !result_valid) begin
                exec_seen++;
                if (rst_on_exec && !rst_hit) begin
                    rst = 1;
                    rst_hit = 1;
                    rst_left = 2;
                    btn_next = 0;
                    btn_clear = 0;
                end
            end
        end
    endtask

    task automatic do_op(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
        if (m_state == M_SH) press(1, 0);
        sw_data = a; press(1, 0);
        sw_data = b; press(1, 0);
        sw_sel  = s; press(1, 0);
    endtask

    initial begin
        logic [2:0] la, lb;
        logic [1:0] ls;
        // 1: reset
        repeat (2) @(negedge clk);
        en = 1;
        ck("rst_op_a", {5'd0, op_a}, 8'd0);
        ck("rst_result_q", {5'd0, result_q}, 8'd0);
        ck("rst_valid", {7'd0, result_valid}, 8'd0);
        ck("rst_phase", {5'd0, phase}, 8'h01);
        ck("rst_count", op_count, 8'd0);
        rst = 0;
        repeat (3) @(negedge clk);
        btn_next = 1; btn_clear = 1; rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (20) @(negedge clk);
        ck("held_through_rst_phase", {5'd0, phase}, 8'h01);
        btn_next = 0; btn_clear = 0;
        repeat (HOLD) @(negedge clk);

        // 2: full operation, AND then NOT A
        exec_seen = 0;
        do_op(3'b101, 3'b011, 2'b00);
        ck("op1_exec_cycles", 8'(exec_seen), 8'd1);
        ck("op1_op_a", {5'd0, op_a}, 8'h05);
        ck("op1_op_b", {5'd0, op_b}, 8'h03);
        ck("op1_op_s", {6'd0, op_s}, 8'h00);
        ck("op1_result", {5'd0, result_q}, 8'h01);
        ck("op1_valid", {7'd0, result_valid}, 8'd1);
        ck("op1_count", op_count, 8'd1);
        do_op(3'b101, 3'b011, 2'b11);
        ck("op2_result", {5'd0, result_q}, 8'h02);
        ck("op2_count", op_count, 8'd2);

        // 3: bounce, then a long hold: exactly one advance (SHOW -> LOAD_A)
        for (int i = 0; i < 20; i++) begin
            btn_next = ((i / 2) % 2 == 0);
            @(negedge clk);
        end
        btn_next = 1;
        repeat (10) @(negedge clk);
        ck("bounce_phase", {5'd0, phase}, 8'h01);
        ck("bounce_valid", {7'd0, result_valid}, 8'd0);
        repeat (1000) @(negedge clk);
        ck("hold_phase", {5'd0, phase}, 8'h01);
        btn_next = 0;
        repeat (HOLD) @(negedge clk);

        // 4: clear in LOAD_S, then clear+next together in LOAD_B
        sw_data = 3'b110; press(1, 0);
        sw_data = 3'b001; press(1, 0);
        ck("pre_clear_phase", {5'd0, phase}, 8'h04);
        press(0, 1);
        ck("clear_phase", {5'd0, phase}, 8'h01);
        ck("clear_op_a", {5'd0, op_a}, 8'd0);
        ck("clear_op_b", {5'd0, op_b}, 8'd0);
        ck("clear_count", op_count, 8'd2);
        sw_data = 3'b111; press(1, 0);
        ck("load_b_phase", {5'd0, phase}, 8'h02);
        press(1, 1);
        ck("both_phase", {5'd0, phase}, 8'h01);
        ck("both_op_a", {5'd0, op_a}, 8'd0);

        // 5: reset on the EXEC cycle
        rst_on_exec = 1;
        do_op(3'b111, 3'b010, 2'b01);
        rst_on_exec = 0;
        repeat (HOLD) @(negedge clk);
        ck("exec_rst_hit", {7'd0, rst_hit}, 8'd1);
        ck("exec_rst_valid", {7'd0, result_valid}, 8'd0);
        ck("exec_rst_result", {5'd0, result_q}, 8'd0);
        ck("exec_rst_count", op_count, 8'd0);
        ck("exec_rst_phase", {5'd0, phase}, 8'h01);

        // 6: 256 operations wrap the counter
        la = 0; lb = 0; ls = 0;
        for (int i = 0; i < 256; i++) begin
            la = 3'(i);
            lb = 3'(i * 3 + 1);
            ls = 2'(i / 8);
            do_op(la, lb, ls);
        end
        ck("wrap_count", op_count, 8'd0);
        ck("wrap_valid", {7'd0, result_valid}, 8'd1);
        ck("wrap_result", {5'd0, result_q}, {5'd0, alu_f(la, lb, ls)});

        en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
